// File: rtl/comp_pkg.sv
// Shared constants and helpers for the round-robin comparator scheduler.
// Result encodings are {lt,eq,gt}; clog2 sizes requester ids.
package comp_pkg;

    localparam logic [2:0] RES_LT = 3'b100;
    localparam logic [2:0] RES_EQ = 3'b010;
    localparam logic [2:0] RES_GT = 3'b001;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/comp_n.sv
// Unsigned DW-bit magnitude comparator; purely combinational.
// Zero latency, no flow control.
module comp_n #(
    parameter int DW = 32
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic          lt,
    output logic          eq,
    output logic          gt
);

    assign lt = (a < b);
    assign eq = (a == b);
    assign gt = (a > b);

endmodule

// File: rtl/rr_arb.sv
// Round-robin pick: first set bit of req searching upward from ptr, modulo NREQ.
// Purely combinational; zero latency, no flow control.
module rr_arb
    import comp_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] win_oh,
    output logic [IDW-1:0]  win_id,
    output logic            any
);

    int idx;

    always_comb begin
        win_oh = '0;
        win_id = '0;
        any    = 1'b0;
        idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!any && req[idx]) begin
                any         = 1'b1;
                win_oh[idx] = 1'b1;
                win_id      = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/comp_rr_sched.sv
// Round-robin sharing of one comp_n among NREQ requesters; one grant and one result per cycle.
// Latency: req sampled at edge T, gnt after T, done after T+1; requesters are never stalled, only deferred.
module comp_rr_sched
    import comp_pkg::*;
#(
    parameter  int DW   = 32,
    parameter  int NREQ = 4,
    localparam int IDW  = clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] a_in,
    input  logic [NREQ*DW-1:0] b_in,
    output logic [NREQ-1:0]    gnt,
    output logic               done,
    output logic [IDW-1:0]     done_id,
    output logic               lt,
    output logic               eq,
    output logic               gt
);

    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] win_oh;
    logic [IDW-1:0]  win_id;
    logic            any;
    logic [IDW-1:0]  ptr;
    logic [DW-1:0]   op_a;
    logic [DW-1:0]   op_b;
    logic [IDW-1:0]  op_id;
    logic            c_lt;
    logic            c_eq;
    logic            c_gt;
    logic [2:0]      res;

    // A requester currently holding gnt is skipped so it cannot be granted twice while it drops req.
    assign elig = req & ~gnt;

    rr_arb #(
        .NREQ(NREQ)
    ) u_arb (
        .req    (elig),
        .ptr    (ptr),
        .win_oh (win_oh),
        .win_id (win_id),
        .any    (any)
    );

    comp_n #(
        .DW(DW)
    ) u_cmp (
        .a  (op_a),
        .b  (op_b),
        .lt (c_lt),
        .eq (c_eq),
        .gt (c_gt)
    );

    always_comb begin
        res = RES_GT;
        if (c_lt) begin
            res = RES_LT;
        end else if (c_eq) begin
            res = RES_EQ;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt     <= '0;
            ptr     <= '0;
            op_a    <= '0;
            op_b    <= '0;
            op_id   <= '0;
            done    <= 1'b0;
            done_id <= '0;
            lt      <= 1'b0;
            eq      <= 1'b0;
            gt      <= 1'b0;
        end else begin
            if (any) begin
                gnt   <= win_oh;
                ptr   <= (int'(win_id) == NREQ - 1) ? '0 : win_id + 1'b1;
                op_a  <= a_in[int'(win_id)*DW +: DW];
                op_b  <= b_in[int'(win_id)*DW +: DW];
                op_id <= win_id;
            end else begin
                gnt <= '0;
            end
            // A live grant means op_a/op_b/op_id hold that requester's operands this cycle.
            done <= |gnt;
            if (|gnt) begin
                done_id      <= op_id;
                {lt, eq, gt} <= res;
            end
        end
    end

endmodule
